mci_arbiter: RTL and testbench

//  Round-robin arbiter sharing one memory-controller-interface (MCI) port among NUM_CLIENTS requesters (icache, dcache, ...).

---
 rtl/mci_arbiter_pkg.sv | 36 +++
 rtl/mci_arbiter_rr_picker.sv | 32 +++
 rtl/mci_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mci_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mci_arbiter_pkg.sv
// Package memory_controller_interface: MCI request/response types shared by clients, arbiter and memory,
// plus the arbiter's state encoding, client limit and a round-robin index helper.
package memory_controller_interface;

  localparam int MCI_ADDR_W          = 32;
  localparam int MCI_BLOCK_W         = 128;
  localparam int MCI_ARB_MAX_CLIENTS = 8;
  localparam int MCI_ARB_IDX_W       = $clog2(MCI_ARB_MAX_CLIENTS);

  typedef struct packed {
    logic                   valid;
    logic                   rw;
    logic [MCI_ADDR_W-1:0]  addr;
    logic [MCI_BLOCK_W-1:0] data;
  } mci_request_t;

  typedef struct packed {
    logic                   ready;
    logic [MCI_BLOCK_W-1:0] data;
  } mci_response_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } mci_arb_state_t;

  typedef logic [MCI_ARB_IDX_W-1:0] mci_arb_idx_t;

  // Client index reached by stepping `off` places past `base` in a ring of `n` clients.
  function automatic mci_arb_idx_t mci_arb_wrap(input int base, input int off, input int n);
    return mci_arb_idx_t'((base + off) % n);
  endfunction

endpackage

// File: rtl/mci_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection of the first pending client after last_grant.
module rr_picker
  import memory_controller_interface::*;
#(
  parameter int NUM_CLIENTS = 2
) (
  input  logic [NUM_CLIENTS-1:0] pending,
  input  mci_arb_idx_t           last_grant,
  output mci_arb_idx_t           grant,
  output logic                   any_pending
);

  logic [MCI_ARB_MAX_CLIENTS-1:0] pending_ext;
  mci_arb_idx_t                   cand;

  // Search starts one past the previous winner, so the last winner has lowest priority.
  always_comb begin
    pending_ext                    = '0;
    pending_ext[NUM_CLIENTS-1:0]   = pending;
    grant                          = '0;
    any_pending                    = 1'b0;
    cand                           = '0;
    for (int off = 1; off <= NUM_CLIENTS; off++) begin
      cand = mci_arb_wrap(int'(last_grant), off, NUM_CLIENTS);
      if (!any_pending && pending_ext[cand]) begin
        any_pending = 1'b1;
        grant       = cand;
      end
    end
  end

endmodule

// File: rtl/mci_arbiter.sv
// mci_arbiter: round-robin arbiter serialising NUM_CLIENTS requesters onto one MCI port, one request in flight.
// Defining MCI_ARB_PERF_EN adds per-client grant counters and a WAIT-cycle counter.
module mci_arbiter
  import memory_controller_interface::*;
#(
  parameter int NUM_CLIENTS = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  mci_request_t  [NUM_CLIENTS-1:0] client_req,
  output mci_response_t [NUM_CLIENTS-1:0] client_res,
  output mci_request_t                    mem_req,
  input  mci_response_t                   mem_res,
  output logic                            o_busy,
  output logic                            o_proto_err
`ifdef MCI_ARB_PERF_EN
  ,
  output logic [NUM_CLIENTS-1:0][31:0]    o_grant_cnt,
  output logic [31:0]                     o_wait_cnt
`endif
);

  mci_arb_state_t                             state_q, state_d;
  mci_arb_idx_t                               grant_q, grant_d;
  mci_arb_idx_t                               last_grant_q, last_grant_d;
  logic [NUM_CLIENTS-1:0]                     pending_q, pending_d;
  logic [NUM_CLIENTS-1:0]                     slot_rw_q, slot_rw_d;
  logic [NUM_CLIENTS-1:0][MCI_ADDR_W-1:0]     slot_addr_q, slot_addr_d;
  logic [NUM_CLIENTS-1:0][MCI_BLOCK_W-1:0]    slot_data_q, slot_data_d;
  logic                                       req_rw_q, req_rw_d;
  logic [MCI_ADDR_W-1:0]                      req_addr_q, req_addr_d;
  logic [MCI_BLOCK_W-1:0]                     req_data_q, req_data_d;
  logic [MCI_BLOCK_W-1:0]                     rdata_q, rdata_d;
  logic                                       proto_err_q, proto_err_d;

  logic [NUM_CLIENTS-1:0]                     in_flight;
  mci_arb_idx_t                               pick_idx;
  logic                                       pick_valid;

  rr_picker #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_picker (
    .pending     (pending_q),
    .last_grant  (last_grant_q),
    .grant       (pick_idx),
    .any_pending (pick_valid)
  );

  // A client is in flight once issued to memory and until its RESPOND cycle, where re-requesting is legal.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      in_flight[i] = ((state_q == ISSUE) || (state_q == WAIT)) && (grant_q == mci_arb_idx_t'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pending_d    = pending_q;
    slot_rw_d    = slot_rw_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    req_rw_d     = req_rw_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    rdata_d      = rdata_q;
    proto_err_d  = proto_err_q;

    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (client_req[i].valid) begin
        if (pending_q[i] || in_flight[i]) begin
          proto_err_d = 1'b1;
        end else begin
          pending_d[i]   = 1'b1;
          slot_rw_d[i]   = client_req[i].rw;
          slot_addr_d[i] = client_req[i].addr;
          slot_data_d[i] = client_req[i].data;
        end
      end
    end

    // A granted slot cannot capture in the same cycle: its pending bit makes any new pulse illegal.
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (pick_idx == mci_arb_idx_t'(i)) begin
              pending_d[i] = 1'b0;
              req_rw_d     = slot_rw_q[i];
              req_addr_d   = slot_addr_q[i];
              req_data_d   = slot_data_q[i];
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_res.ready) begin
          rdata_d = mem_res.data;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= mci_arb_idx_t'(NUM_CLIENTS - 1);
      pending_q    <= '0;
      slot_rw_q    <= '0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      req_rw_q     <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      rdata_q      <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      slot_rw_q    <= slot_rw_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      req_rw_q     <= req_rw_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      rdata_q      <= rdata_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Address/rw/data stay on the port through WAIT so a combinational memory can keep reading them.
  always_comb begin
    mem_req       = '0;
    mem_req.valid = (state_q == ISSUE);
    mem_req.rw    = req_rw_q;
    mem_req.addr  = req_addr_q;
    mem_req.data  = req_data_q;
  end

  always_comb begin
    client_res = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if ((state_q == RESPOND) && (grant_q == mci_arb_idx_t'(i))) begin
        client_res[i].ready = 1'b1;
        client_res[i].data  = rdata_q;
      end
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_proto_err = proto_err_q;

`ifdef MCI_ARB_PERF_EN
  logic [NUM_CLIENTS-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]                  wait_cnt_q, wait_cnt_d;

  // Both counters wrap naturally at 2^32.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q + 32'd1;
    end
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if ((state_q == RESPOND) && (grant_q == mci_arb_idx_t'(i))) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign o_grant_cnt = grant_cnt_q;
  assign o_wait_cnt  = wait_cnt_q;
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_mci_arbiter.sv
// tb_mci_arbiter: directed and randomized checks of mci_arbiter against a transaction-level reference model.
// The model tracks requests as whole transactions; a simple 1-cycle memory device answers mem_req.
`timescale 1ns/1ps
module tb_mci_arbiter;
  import memory_controller_interface::*;

  localparam int N            = 2;
  localparam int DRAIN_BUDGET = 300;

  logic                    i_clk = 1'b0;
  logic                    i_rst;
  mci_request_t  [N-1:0]   client_req;
  mci_response_t [N-1:0]   client_res;
  mci_request_t            mem_req;
  mci_response_t           mem_res;
  logic                    o_busy;
  logic                    o_proto_err;
`ifdef MCI_ARB_PERF_EN
  logic [N-1:0][31:0]      o_grant_cnt;
  logic [31:0]             o_wait_cnt;
`endif

  mci_arbiter #(
    .NUM_CLIENTS (N)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .client_req  (client_req),
    .client_res  (client_res),
    .mem_req     (mem_req),
    .mem_res     (mem_res),
    .o_busy      (o_busy),
`ifdef MCI_ARB_PERF_EN
    .o_grant_cnt (o_grant_cnt),
    .o_wait_cnt  (o_wait_cnt),
`endif
    .o_proto_err (o_proto_err)
  );

  always #5 i_clk = ~i_clk;

  // Memory device: answers every valid pulse with ready one cycle later; data is noise when not ready.
  logic [127:0] mem_array [256];
  always @(posedge i_clk) begin
    if (i_rst) begin
      mem_res <= '0;
    end else begin
      mem_res.ready <= mem_req.valid;
      mem_res.data  <= {$urandom, $urandom, $urandom, $urandom};
      if (mem_req.valid) begin
        if (mem_req.rw) mem_array[mem_req.addr[11:4]] <= mem_req.data;
        else            mem_res.data <= mem_array[mem_req.addr[11:4]];
      end
    end
  end

  typedef struct {
    int           client;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
    int           cyc;
  } txn_t;

  txn_t         waiting[$];
  bit           client_busy [N];
  bit           inflight;
  txn_t         cur;
  int           cur_issue;
  logic [127:0] cur_rdata;
  int           last_served;
  bit           exp_err;
  logic [127:0] shadow [256];
  int           cycle;
  int           n_issues;
  int           n_done;
  int           done_cnt [N];
  int           wait_model;
  int           last_done_cycle;
  int           serve_log[$];
  bit           ready_seen [N];
  logic [127:0] last_rdata [N];
  int           passed;
  int           total;

  function automatic logic [127:0] blockPattern(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(k)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    waiting.delete();
    for (int c = 0; c < N; c++) begin
      client_busy[c] = 1'b0;
      done_cnt[c]    = 0;
    end
    inflight    = 1'b0;
    last_served = N - 1;
    exp_err     = 1'b0;
    wait_model  = 0;
  endtask

  // Per-cycle observation: issue order, hold, busy, error flag, response routing and timing.
  task automatic checkOutput();
    int sel;
    int c;
    bit exp_rdy;
    for (int k = 0; k < N; k++) ready_seen[k] = 1'b0;
    if (mem_req.valid) begin
      sel = -1;
      for (int off = 1; off <= N; off++) begin
        c = (last_served + off) % N;
        for (int k = 0; k < waiting.size(); k++)
          if (sel < 0 && waiting[k].client == c && waiting[k].cyc <= cycle - 2) sel = k;
      end
      chk("issue_legal", (!inflight && sel >= 0), 1'b1);
      if (!inflight && sel >= 0) begin
        cur = waiting[sel];
        waiting.delete(sel);
        chk("issue_addr", mem_req.addr, cur.addr);
        chk("issue_rw", mem_req.rw, cur.rw);
        if (cur.rw) chk("issue_wdata", mem_req.data, cur.data);
        inflight  = 1'b1;
        cur_issue = cycle;
        n_issues++;
        if (cur.rw) begin
          shadow[cur.addr[11:4]] = cur.data;
          cur_rdata = '0;
        end else begin
          cur_rdata = shadow[cur.addr[11:4]];
        end
      end
    end
    if (inflight && cycle == cur_issue + 1) begin
      chk("wait_addr_hold", mem_req.addr, cur.addr);
      chk("wait_valid_low", mem_req.valid, 1'b0);
      wait_model++;
    end
    chk("busy", o_busy, inflight);
    chk("proto_err", o_proto_err, exp_err);
    for (int k = 0; k < N; k++) begin
      exp_rdy = inflight && cur.client == k && cycle == cur_issue + 2;
      chk("client_ready", client_res[k].ready, exp_rdy);
      if (exp_rdy) begin
        if (!cur.rw) chk("client_rdata", client_res[k].data, cur_rdata);
        last_rdata[k] = client_res[k].data;
      end else begin
        chk("idle_data_zero", client_res[k].data, '0);
      end
    end
    if (inflight && cycle == cur_issue + 2) begin
      client_busy[cur.client] = 1'b0;
      last_served             = cur.client;
      done_cnt[cur.client]++;
      n_done++;
      last_done_cycle         = cycle;
      serve_log.push_back(cur.client);
      ready_seen[cur.client]  = 1'b1;
      inflight                = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cycle++;
    client_req = '0;
    checkOutput();
  endtask

  task automatic applyStimulus(input int c, input logic a_rw, input logic [31:0] a_addr,
                               input logic [127:0] a_data);
    client_req[c].valid = 1'b1;
    client_req[c].rw    = a_rw;
    client_req[c].addr  = a_addr;
    client_req[c].data  = a_data;
    if (client_busy[c]) begin
      exp_err = 1'b1;
    end else begin
      waiting.push_back('{client: c, rw: a_rw, addr: a_addr, data: a_data, cyc: cycle});
      client_busy[c] = 1'b1;
    end
  endtask

  task automatic randReq(input int c);
    logic [7:0] idx8;
    idx8 = 8'($urandom_range(0, 255));
    applyStimulus(c, 1'($urandom_range(0, 1)), {20'h0, idx8, 4'h0},
                  {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((inflight || waiting.size() > 0) && n < DRAIN_BUDGET) begin
      tick();
      n++;
    end
    chk("drain_complete", (inflight || waiting.size() > 0), 1'b0);
    tick();
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    modelReset();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic checkPerf(input string tag);
`ifdef MCI_ARB_PERF_EN
    for (int c = 0; c < N; c++) chk({tag, "_grant_cnt"}, o_grant_cnt[c], done_cnt[c]);
    chk({tag, "_wait_cnt"}, o_wait_cnt, wait_model);
`else
    $display("[TB] %s: performance counters not built", tag);
`endif
  endtask

  initial begin
    int base_issues;
    int base_done;
    int pulse_cycle;
    int req_made;
    int n;
    passed     = 0;
    total      = 0;
    cycle      = 0;
    n_issues   = 0;
    n_done     = 0;
    client_req = '0;
    i_rst      = 1'b1;
    for (int k = 0; k < 256; k++) begin
      mem_array[k] = blockPattern(k);
      shadow[k]    = blockPattern(k);
    end
    for (int k = 0; k < N; k++) last_rdata[k] = '0;
    modelReset();
    tick();
    tick();
    chk("rst_mem_valid", mem_req.valid, 1'b0);
    chk("rst_mem_addr", mem_req.addr, '0);
    chk("rst_mem_data", mem_req.data, '0);
    chk("rst_res0", {client_res[0].ready, client_res[0].data}, '0);
    chk("rst_res1", {client_res[1].ready, client_res[1].data}, '0);
    i_rst = 1'b0;

    $display("[TB] test 1: single read");
    base_issues = n_issues;
    pulse_cycle = cycle;
    applyStimulus(0, 1'b0, 32'h0000_0040, '0);
    drain();
    chk("t1_issues", n_issues - base_issues, 1);
    chk("t1_latency", last_done_cycle - pulse_cycle, 4);
    chk("t1_data", last_rdata[0], blockPattern(4));
    chk("t1_client1_silent", done_cnt[1], 0);

    $display("[TB] test 2: write then read");
    applyStimulus(1, 1'b1, 32'h0000_0100, {4{32'hDEADBEEF}});
    drain();
    applyStimulus(1, 1'b0, 32'h0000_0100, '0);
    drain();
    chk("t2_readback", last_rdata[1], {4{32'hDEADBEEF}});

    $display("[TB] test 3: tie after reset");
    doReset();
    serve_log.delete();
    base_issues = n_issues;
    applyStimulus(0, 1'b0, 32'h0000_0010, '0);
    applyStimulus(1, 1'b0, 32'h0000_0020, '0);
    drain();
    chk("t3_issues", n_issues - base_issues, 2);
    chk("t3_count", serve_log.size(), 2);
    if (serve_log.size() == 2) begin
      chk("t3_first", serve_log[0], 0);
      chk("t3_second", serve_log[1], 1);
    end

    $display("[TB] test 4: fairness under continuous requests");
    serve_log.delete();
    req_made = 0;
    for (int c = 0; c < N; c++) begin
      randReq(c);
      req_made++;
    end
    n = 0;
    while (serve_log.size() < 20 && n < 400) begin
      tick();
      n++;
      for (int c = 0; c < N; c++)
        if (ready_seen[c] && req_made < 20) begin
          randReq(c);
          req_made++;
        end
    end
    drain();
    chk("t4_count", serve_log.size(), 20);
    for (int k = 0; k < serve_log.size() && k < 20; k++) chk("t4_order", serve_log[k], k % 2);
    checkPerf("t4_perf");

    $display("[TB] test 5: protocol error");
    base_issues = n_issues;
    base_done   = n_done;
    applyStimulus(0, 1'b0, 32'h0000_0080, '0);
    tick();
    applyStimulus(0, 1'b0, 32'h0000_00C0, '0);
    drain();
    chk("t5_issues", n_issues - base_issues, 1);
    chk("t5_readies", n_done - base_done, 1);
    chk("t5_err_sticky", o_proto_err, 1'b1);

    $display("[TB] random phase");
    for (int t = 0; t < 300; t++) begin
      tick();
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 99) < 25) randReq(c);
    end
    drain();

    $display("[TB] test 6: reset during WAIT");
    doReset();
    applyStimulus(1, 1'b0, 32'h0000_0200, '0);
    n = 0;
    while (!inflight && n < 20) begin
      tick();
      n++;
    end
    chk("t6_reached_issue", inflight, 1'b1);
    tick();
    i_rst = 1'b1;
    modelReset();
    tick();
    i_rst = 1'b0;
    chk("t6_mem_req_zero", {mem_req.valid, mem_req.rw, mem_req.addr}, '0);
    chk("t6_mem_data_zero", mem_req.data, '0);
    chk("t6_res0_zero", {client_res[0].ready, client_res[0].data}, '0);
    chk("t6_res1_zero", {client_res[1].ready, client_res[1].data}, '0);
    chk("t6_busy_zero", o_busy, 1'b0);
    for (int t = 0; t < 4; t++) tick();
    base_done = n_done;
    applyStimulus(0, 1'b0, 32'h0000_0300, '0);
    drain();
    chk("t6_recovered", n_done - base_done, 1);
    chk("t6_data", last_rdata[0], shadow[8'h30]);
    checkPerf("final_perf");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
